// File: rtl/fifo_flags.sv
// Synchronous FWFT FIFO of arbitrary depth N with fill count, programmable almost flags
// and sticky overflow/underflow error flags.
module fifo_flags #(
    parameter int N  = 6,
    parameter int M  = 16,
    parameter int AF = N - 1,
    parameter int AE = 1,
    localparam int W  = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [M-1:0]  din,
    input  logic          write,
    output logic          full,
    output logic          almost_full,
    output logic [M-1:0]  dout,
    input  logic          read,
    output logic          empty,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    logic [M-1:0]  mem_q [N];
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_ok, wr_ok;

    // Exact modulo-N advance, so non-power-of-two depths never index past N-1.
    function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
        return (p == W'(N - 1)) ? '0 : p + W'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(N));
    assign almost_full  = (count_q >= CW'(AF));
    assign almost_empty = (count_q <= CW'(AE));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign dout         = empty ? '0 : mem_q[head_q];

    // A simultaneous read frees the head slot, so a write into a full FIFO still lands.
    assign rd_ok = read && !empty;
    assign wr_ok = write && (!full || read);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rd_ok) head_d = ptr_inc(head_q);
        if (wr_ok) tail_d = ptr_inc(tail_q);
        if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    end

    // Setting an error flag takes priority over clearing it in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (write && !wr_ok) ovf_d = 1'b1;
        else if (clr_err)    ovf_d = 1'b0;
        if (read && !rd_ok)  udf_d = 1'b1;
        else if (clr_err)    udf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[tail_q] <= din;
        end
    end

endmodule

// File: tb/tb_fifo_flags.sv
// Randomised and directed bench for fifo_flags against a queue-based reference model.
module tb_fifo_flags;
    localparam int N  = 6;
    localparam int M  = 16;
    localparam int AF = N - 1;
    localparam int AE = 1;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [M-1:0]  din = '0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic          clr_err = 1'b0;
    logic          full, almost_full, empty, almost_empty, overflow, underflow;
    logic [M-1:0]  dout;
    logic [CW-1:0] count;

    fifo_flags #(.N(N), .M(M), .AF(AF), .AE(AE)) dut (
        .clk(clk), .rst(rst), .din(din), .write(write), .full(full),
        .almost_full(almost_full), .dout(dout), .read(read), .empty(empty),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a queue plus the two sticky flags.
    logic [M-1:0] q[$];
    bit m_ovf = 0;
    bit m_udf = 0;
    bit model_valid = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_dout();
        return (q.size() == 0) ? 0 : int'(q[0]);
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("count",        int'(count),        q.size());
            chk("empty",        int'(empty),        int'(q.size() == 0));
            chk("full",         int'(full),         int'(q.size() == N));
            chk("almost_full",  int'(almost_full),  int'(q.size() >= AF));
            chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
            chk("dout",         int'(dout),         m_dout());
            chk("overflow",     int'(overflow),     int'(m_ovf));
            chk("underflow",    int'(underflow),    int'(m_udf));
        end
    end

    task automatic model_update();
        bit rd_ok, wr_ok;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            rd_ok = read && (q.size() > 0);
            wr_ok = write && ((q.size() < N) || read);
            if (write && !wr_ok) m_ovf = 1;
            else if (clr_err)    m_ovf = 0;
            if (read && !rd_ok)  m_udf = 1;
            else if (clr_err)    m_udf = 0;
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(din);
        end
    endtask

    task automatic cycle(input bit w, input bit r, input logic [M-1:0] d,
                         input bit c = 0, input bit rs = 0);
        write = w; read = r; din = d; clr_err = c; rst = rs;
        @(posedge clk);
        #1;
        model_update();
        model_valid = 1;
        write = 0; read = 0; clr_err = 0; rst = 0;
    endtask

    initial begin
        logic [M-1:0] got[$];
        @(negedge clk);

        // Reset with write held high
        cycle(1, 0, 16'h00AA, 0, 1);
        cycle(1, 0, 16'h00AA, 0, 1);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_dout", int'(dout), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_udf", int'(underflow), 0);

        // Fill and drain
        for (int i = 1; i <= 6; i++) cycle(1, 0, M'(i));
        chk("fill_count", int'(count), 6);
        chk("fill_full", int'(full), 1);
        for (int i = 1; i <= 6; i++) begin
            chk("drain_dout", int'(dout), i);
            cycle(0, 1, '0);
        end
        chk("drain_empty", int'(empty), 1);

        // Overflow and clear
        for (int i = 1; i <= 6; i++) cycle(1, 0, M'(i));
        cycle(1, 0, 16'hDEAD);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 6);
        chk("ovf_dout", int'(dout), 1);
        cycle(0, 0, '0, 1);
        chk("ovf_clr", int'(overflow), 0);

        // Full with simultaneous read/write
        cycle(1, 1, 16'd7);
        chk("fullrw_dout", int'(dout), 2);
        chk("fullrw_count", int'(count), 6);
        chk("fullrw_ovf", int'(overflow), 0);
        chk("fullrw_full", int'(full), 1);
        for (int i = 0; i < 6; i++) begin
            got.push_back(dout);
            cycle(0, 1, '0);
        end
        for (int i = 0; i < 6; i++) chk("fullrw_order", int'(got[i]), i + 2);

        // Empty with simultaneous read/write
        cycle(1, 1, 16'h0055);
        chk("emptyrw_udf", int'(underflow), 1);
        chk("emptyrw_count", int'(count), 1);
        chk("emptyrw_dout", int'(dout), 16'h0055);
        cycle(0, 1, '0, 1);
        chk("udf_clr", int'(underflow), 0);

        // Wrap under continuous read/write
        for (int i = 0; i < 3; i++) cycle(1, 0, M'($urandom));
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, M'($urandom));
            chk("head_range", int'(dut.head_q <= 5), 1);
            chk("tail_range", int'(dut.tail_q <= 5), 1);
        end
        chk("wrap_count", int'(count), 3);

        // Random traffic, biased in phases to visit both boundaries
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 200) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(99, 0) < wp, $urandom_range(99, 0) < (100 - wp),
                  M'($urandom), $urandom_range(19, 0) == 0, $urandom_range(299, 0) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
